ifetch_decode: RTL and testbench

- Instruction fetch and decode unit: the producer for the control FSM's instruction inputs (opcode, register selects, immediate, flag_type).
- On a fetch request, reads one 16-bit instruction word from instruction memory at the current PC.
- Latches the word into the instruction register and decodes it.
- Presents the decoded fields under a valid/ack handshake until the control FSM consumes them.

---
 rtl/cpu_isa_pkg.sv | 37 +++
 rtl/ir_field_decoder.sv | 61 ++++++
 rtl/ifetch_decode.sv | 131 +++++++++++++
 tb/tb_ifetch_decode.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch/decode slice: op and opext codes,
// flag_type class codes and the fetch FSM state encoding.
// Optional build macro: IFD_ILLEGAL_DETECT_EN (undefined ops flagged illegal).
package cpu_isa_pkg;

  // Major opcode field ir[15:12]
  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1100;

  // Opcode extension field ir[7:4], meaningful for OP_MEM
  localparam logic [3:0] OPEXT_LOAD  = 4'b0000;
  localparam logic [3:0] OPEXT_STORE = 4'b0100;

  // Instruction class codes presented to the control FSM
  localparam logic [3:0] FT_ILLEGAL = 4'b0000;
  localparam logic [3:0] FT_RTYPE   = 4'b0001;
  localparam logic [3:0] FT_IMM     = 4'b0010;
  localparam logic [3:0] FT_LOAD    = 4'b0100;
  localparam logic [3:0] FT_STORE   = 4'b0101;
  localparam logic [3:0] FT_BRANCH  = 4'b1100;
  localparam logic [3:0] FT_JUMP    = 4'b1101;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

  // Major opcodes that carry an 8-bit immediate in ir[7:0]
  function automatic logic is_imm_op(input logic [3:0] op);
    return op inside {4'b0001, 4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b1000};
  endfunction

endpackage

// File: rtl/ir_field_decoder.sv
// Purely combinational instruction-word field decoder. Also used by the
// debug display logic, so it carries no state.
// Optional build macro: IFD_ILLEGAL_DETECT_EN adds the illegal output.
module ir_field_decoder
  import cpu_isa_pkg::*;
(
  input  logic [15:0] ir,
  output logic [7:0]  opcode,
  output logic [4:0]  rdst,
  output logic [4:0]  rsrc,
  output logic [7:0]  immediate,
  output logic [3:0]  flag_type
`ifdef IFD_ILLEGAL_DETECT_EN
  ,
  output logic        illegal
`endif
);

  logic [3:0] op;
  logic [3:0] opext;

  assign op        = ir[15:12];
  assign opext     = ir[7:4];
  assign opcode    = {op, opext};
  assign rdst      = {1'b0, ir[11:8]};
  assign rsrc      = {1'b0, ir[3:0]};
  assign immediate = ir[7:0];

  // Classify the instruction from op and opext
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    flag_type = FT_RTYPE;
`ifdef IFD_ILLEGAL_DETECT_EN
    illegal   = 1'b0;
`endif
    case (op)
      OP_RTYPE:  flag_type = FT_RTYPE;
      OP_MEM: begin
        if (opext == OPEXT_LOAD)       flag_type = FT_LOAD;
        else if (opext == OPEXT_STORE) flag_type = FT_STORE;
        else                           flag_type = FT_JUMP;
      end
      OP_BRANCH: flag_type = FT_BRANCH;
      default: begin
        if (is_imm_op(op)) begin
          flag_type = FT_IMM;
        end else begin
`ifdef IFD_ILLEGAL_DETECT_EN
          flag_type = FT_ILLEGAL;
          illegal   = 1'b1;
`else
          // Undefined ops fall back to R-type when detection is not built in
          flag_type = FT_RTYPE;
`endif
        end
      end
    endcase
  end

endmodule

// File: rtl/ifetch_decode.sv
// Instruction fetch and decode unit. Fetches one 16-bit word at the caller's
// PC, holds it in the instruction register and presents the decoded fields
// under an ir_valid/ir_ack handshake.
// Optional build macro: IFD_ILLEGAL_DETECT_EN (adds illegal_out).
module ifetch_decode
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1   // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic [7:0]        opcode_out,
  output logic [4:0]        rdst_out,
  output logic [4:0]        rsrc_out,
  output logic [7:0]        immediate_out,
  output logic [3:0]        flag_type_out,
  output logic              busy,
  output logic              overrun
`ifdef IFD_ILLEGAL_DETECT_EN
  ,
  output logic              illegal_out
`endif
);

  // Cycles spent in WAIT after the strobe cycle, minus one
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [2:0]        lat_q, lat_d;
  logic              overrun_q, overrun_d;
  logic              req_ignored;

  // Next-state, address, IR and latency-counter logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          addr_d  = pc_in;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        lat_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 3'd0) begin
          ir_d    = mem_rdata;
          state_d = ST_VALID;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_VALID: begin
        if (ir_ack) begin
          if (fetch_req) begin
            addr_d  = pc_in;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request the FSM cannot accept is dropped and remembered until reset
  assign req_ignored = fetch_req &&
                       ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                        ((state_q == ST_VALID) && !ir_ack));
  assign overrun_d   = overrun_q | req_ignored;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ir_q      <= '0;
      lat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      lat_q     <= lat_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == ST_REQ);
  assign ir_valid  = (state_q == ST_VALID);
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign overrun   = overrun_q;

`ifdef IFD_ILLEGAL_DETECT_EN
  logic dec_illegal;
  assign illegal_out = ir_valid && dec_illegal;
`endif

  ir_field_decoder u_decoder (
    .ir        (ir_q),
    .opcode    (opcode_out),
    .rdst      (rdst_out),
    .rsrc      (rsrc_out),
    .immediate (immediate_out),
    .flag_type (flag_type_out)
`ifdef IFD_ILLEGAL_DETECT_EN
    ,
    .illegal   (dec_illegal)
`endif
  );

endmodule

// File: tb/tb_ifetch_decode.sv
// Bench for ifetch_decode: two instances (MEM_LAT=1 and MEM_LAT=3) driven by
// scenario tasks and compared against a rule-level decode model and a
// latency-accurate memory model.
module tb_ifetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_in         [2];
  logic        fetch_req     [2];
  logic        ir_ack        [2];
  logic [15:0] mem_rdata     [2];
  logic [15:0] mem_addr      [2];
  logic        mem_rd_en     [2];
  logic        ir_valid      [2];
  logic [7:0]  opcode_out    [2];
  logic [4:0]  rdst_out      [2];
  logic [4:0]  rsrc_out      [2];
  logic [7:0]  immediate_out [2];
  logic [3:0]  flag_type_out [2];
  logic        busy          [2];
  logic        overrun       [2];
`ifdef IFD_ILLEGAL_DETECT_EN
  logic        illegal_out   [2];
`endif

  int total = 0;
  int bad   = 0;

  int          lat_of [2] = '{1, 3};
  int          cyc        = 0;
  int          due    [2] = '{-1, -1};
  logic [15:0] word   [2] = '{16'h0000, 16'h0000};

  always #5 clk = ~clk;

  ifetch_decode #(.ADDR_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .pc_in(pc_in[0]), .fetch_req(fetch_req[0]),
    .mem_addr(mem_addr[0]), .mem_rd_en(mem_rd_en[0]), .mem_rdata(mem_rdata[0]),
    .ir_valid(ir_valid[0]), .ir_ack(ir_ack[0]), .opcode_out(opcode_out[0]),
    .rdst_out(rdst_out[0]), .rsrc_out(rsrc_out[0]), .immediate_out(immediate_out[0]),
    .flag_type_out(flag_type_out[0]), .busy(busy[0]), .overrun(overrun[0])
`ifdef IFD_ILLEGAL_DETECT_EN
    , .illegal_out(illegal_out[0])
`endif
  );

  ifetch_decode #(.ADDR_W(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .pc_in(pc_in[1]), .fetch_req(fetch_req[1]),
    .mem_addr(mem_addr[1]), .mem_rd_en(mem_rd_en[1]), .mem_rdata(mem_rdata[1]),
    .ir_valid(ir_valid[1]), .ir_ack(ir_ack[1]), .opcode_out(opcode_out[1]),
    .rdst_out(rdst_out[1]), .rsrc_out(rsrc_out[1]), .immediate_out(immediate_out[1]),
    .flag_type_out(flag_type_out[1]), .busy(busy[1]), .overrun(overrun[1])
`ifdef IFD_ILLEGAL_DETECT_EN
    , .illegal_out(illegal_out[1])
`endif
  );

  // Memory model: word[d] appears on mem_rdata exactly MEM_LAT cycles after
  // the strobe cycle; every other cycle carries the inverted word as garbage.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (mem_rd_en[d] === 1'b1) due[d] = cyc + lat_of[d];
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (cyc == due[d]) ? word[d] : ~word[d];
  end

  // Expected {opcode, rdst, rsrc, immediate, flag_type} from the ISA rules
  function automatic logic [29:0] ref_fields(input logic [15:0] w);
    logic [3:0] op, ext, ft;
    op  = w[15:12];
    ext = w[7:4];
    if (op == 4'd0)                            ft = 4'b0001;
    else if (op == 4'd4)                       ft = (ext == 4'd0) ? 4'b0100 :
                                                    (ext == 4'd4) ? 4'b0101 : 4'b1101;
    else if (op == 4'd12)                      ft = 4'b1100;
    else if (op inside {1, 5, 9, 11, 13, 8})   ft = 4'b0010;
`ifdef IFD_ILLEGAL_DETECT_EN
    else                                       ft = 4'b0000;
`else
    else                                       ft = 4'b0001;
`endif
    return {op, ext, 1'b0, w[11:8], 1'b0, w[3:0], w[7:0], ft};
  endfunction

  function automatic logic ref_illegal(input logic [15:0] w);
    return !(w[15:12] inside {0, 4, 12, 1, 5, 9, 11, 13, 8});
  endfunction

  function automatic logic [29:0] got_fields(input int d);
    return {opcode_out[d], rdst_out[d], rsrc_out[d], immediate_out[d], flag_type_out[d]};
  endfunction

  task automatic test_reset();
    logic [49:0] got, exp;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fetch_req[d] = 1'b0; ir_ack[d] = 1'b0; pc_in[d] = 16'hFFFF;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = {mem_addr[d], mem_rd_en[d], ir_valid[d], busy[d], overrun[d], got_fields(d)};
      exp = {16'h0000, 4'b0000, ref_fields(16'h0000)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_state d=%0d got=%h exp=%h", d, got, exp);
      end
`ifdef IFD_ILLEGAL_DETECT_EN
      total++;
      if (illegal_out[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_illegal d=%0d got=%b exp=0", d, illegal_out[d]);
      end
`endif
    end
    reset = 1'b0;
  endtask

  // One complete fetch from IDLE; optionally leaves the unit in VALID.
  task automatic run_fetch(input int d, input logic [15:0] pc, input logic [15:0] w,
                           input bit do_ack, input bit noise_ack);
    logic [29:0] exp;
    exp = ref_fields(w);
    @(negedge clk);
    fetch_req[d] = 1'b1; pc_in[d] = pc; word[d] = w;
    ir_ack[d] = noise_ack ? ($urandom_range(0, 1) == 1) : 1'b0;
    @(negedge clk);
    fetch_req[d] = 1'b0; pc_in[d] = 16'($urandom);
    total++;
    if ({mem_rd_en[d], mem_addr[d], busy[d], ir_valid[d]} !== {1'b1, pc, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL req_cycle d=%0d got rd_en=%b addr=%h busy=%b valid=%b exp 1 %h 1 0",
               d, mem_rd_en[d], mem_addr[d], busy[d], ir_valid[d], pc);
    end
    ir_ack[d] = noise_ack ? ($urandom_range(0, 1) == 1) : 1'b0;
    for (int i = 0; i < lat_of[d]; i++) begin
      @(negedge clk);
      total++;
      if ({mem_rd_en[d], mem_addr[d], busy[d], ir_valid[d]} !== {1'b0, pc, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL wait_cycle%0d d=%0d got rd_en=%b addr=%h busy=%b valid=%b exp 0 %h 1 0",
                 i, d, mem_rd_en[d], mem_addr[d], busy[d], ir_valid[d], pc);
      end
      ir_ack[d] = noise_ack ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    @(negedge clk);
    ir_ack[d] = 1'b0;
    total++;
    if ({ir_valid[d], busy[d], mem_rd_en[d], got_fields(d)} !== {3'b100, exp}) begin
      bad++;
      $display("FAIL valid_fields d=%0d w=%h got valid=%b busy=%b fields=%h exp 1 0 %h",
               d, w, ir_valid[d], busy[d], got_fields(d), exp);
    end
`ifdef IFD_ILLEGAL_DETECT_EN
    total++;
    if (illegal_out[d] !== ref_illegal(w)) begin
      bad++;
      $display("FAIL illegal_flag d=%0d w=%h got=%b exp=%b", d, w, illegal_out[d], ref_illegal(w));
    end
`endif
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      total++;
      if ({ir_valid[d], got_fields(d)} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL valid_hold d=%0d got valid=%b fields=%h exp 1 %h",
                 d, ir_valid[d], got_fields(d), exp);
      end
    end
    if (do_ack) begin
      ir_ack[d] = 1'b1;
      @(negedge clk);
      ir_ack[d] = 1'b0;
      total++;
      if ({ir_valid[d], busy[d], mem_rd_en[d], got_fields(d)} !== {3'b000, exp}) begin
        bad++;
        $display("FAIL after_ack d=%0d got valid=%b busy=%b rd_en=%b fields=%h exp 0 0 0 %h",
                 d, ir_valid[d], busy[d], mem_rd_en[d], got_fields(d), exp);
      end
`ifdef IFD_ILLEGAL_DETECT_EN
      total++;
      if (illegal_out[d] !== 1'b0) begin
        bad++;
        $display("FAIL illegal_after_ack d=%0d got=%b exp=0", d, illegal_out[d]);
      end
`endif
    end
  endtask

  task automatic test_directed();
    logic [15:0] words [5] = '{16'h0B53, 16'h4402, 16'h4002, 16'h4042, 16'hF000};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5; i++)
        run_fetch(d, 16'h0010 + 16'(i), words[i], 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back(input int d);
    logic [29:0] exp;
    exp = ref_fields(16'hC4A7);
    run_fetch(d, 16'h0010, 16'h0B53, 1'b0, 1'b0);
    ir_ack[d] = 1'b1; fetch_req[d] = 1'b1; pc_in[d] = 16'h0011; word[d] = 16'hC4A7;
    @(negedge clk);
    ir_ack[d] = 1'b0; fetch_req[d] = 1'b0;
    total++;
    if ({mem_rd_en[d], mem_addr[d], ir_valid[d]} !== {1'b1, 16'h0011, 1'b0}) begin
      bad++;
      $display("FAIL b2b_req d=%0d got rd_en=%b addr=%h valid=%b exp 1 0011 0",
               d, mem_rd_en[d], mem_addr[d], ir_valid[d]);
    end
    repeat (lat_of[d] + 1) @(negedge clk);
    total++;
    if ({ir_valid[d], got_fields(d)} !== {1'b1, exp}) begin
      bad++;
      $display("FAIL b2b_valid d=%0d got valid=%b fields=%h exp 1 %h",
               d, ir_valid[d], got_fields(d), exp);
    end
    ir_ack[d] = 1'b1;
    @(negedge clk);
    ir_ack[d] = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] pool [6] = '{16'h0000, 16'h4000, 16'h4040, 16'h4E9F, 16'hC000, 16'h2000};
    logic [15:0] w;
    int d;
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      w = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      run_fetch(d, 16'($urandom), w, 1'b1, 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (overrun[k] !== 1'b0) begin
        bad++;
        $display("FAIL no_spurious_overrun d=%0d got=%b exp=0", k, overrun[k]);
      end
    end
  endtask

  task automatic test_overrun_wait();
    @(negedge clk);
    fetch_req[1] = 1'b1; pc_in[1] = 16'h1234; word[1] = 16'h5A3C;
    @(negedge clk);
    fetch_req[1] = 1'b0;
    @(negedge clk);
    fetch_req[1] = 1'b1; pc_in[1] = 16'hBEEF;
    @(negedge clk);
    fetch_req[1] = 1'b0;
    total++;
    if ({overrun[1], busy[1], mem_addr[1]} !== {2'b11, 16'h1234}) begin
      bad++;
      $display("FAIL overrun_wait got overrun=%b busy=%b addr=%h exp 1 1 1234",
               overrun[1], busy[1], mem_addr[1]);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({ir_valid[1], overrun[1], got_fields(1)} !== {2'b11, ref_fields(16'h5A3C)}) begin
      bad++;
      $display("FAIL overrun_fetch_intact got valid=%b overrun=%b fields=%h exp 1 1 %h",
               ir_valid[1], overrun[1], got_fields(1), ref_fields(16'h5A3C));
    end
    ir_ack[1] = 1'b1;
    @(negedge clk);
    ir_ack[1] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({overrun[1], busy[1], ir_valid[1]} !== 3'b100) begin
      bad++;
      $display("FAIL overrun_sticky got overrun=%b busy=%b valid=%b exp 1 0 0",
               overrun[1], busy[1], ir_valid[1]);
    end
  endtask

  task automatic test_overrun_valid();
    run_fetch(0, 16'h0200, 16'h1F00, 1'b0, 1'b0);
    fetch_req[0] = 1'b1; pc_in[0] = 16'h7777;
    @(negedge clk);
    fetch_req[0] = 1'b0;
    total++;
    if ({ir_valid[0], mem_rd_en[0], overrun[0], mem_addr[0]} !== {3'b101, 16'h0200}) begin
      bad++;
      $display("FAIL overrun_valid got valid=%b rd_en=%b overrun=%b addr=%h exp 1 0 1 0200",
               ir_valid[0], mem_rd_en[0], overrun[0], mem_addr[0]);
    end
    ir_ack[0] = 1'b1;
    @(negedge clk);
    ir_ack[0] = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    logic [49:0] got, exp;
    @(negedge clk);
    fetch_req[1] = 1'b1; pc_in[1] = 16'h4321; word[1] = 16'hB7A5;
    @(negedge clk);
    fetch_req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp = {16'h0000, 4'b0000, ref_fields(16'h0000)};
    for (int d = 0; d < 2; d++) begin
      got = {mem_addr[d], mem_rd_en[d], ir_valid[d], busy[d], overrun[d], got_fields(d)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid_fetch d=%0d got=%h exp=%h", d, got, exp);
      end
    end
    repeat (6) begin
      @(negedge clk);
      total++;
      if ({ir_valid[1], mem_rd_en[1], got_fields(1)} !== {2'b00, ref_fields(16'h0000)}) begin
        bad++;
        $display("FAIL late_rdata_dropped got valid=%b rd_en=%b fields=%h exp 0 0 %h",
                 ir_valid[1], mem_rd_en[1], got_fields(1), ref_fields(16'h0000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    test_overrun_wait();
    test_overrun_valid();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout exceeded 1000000 time units");
    $fatal(1, "timeout");
  end

endmodule
